// File: rtl/reg_writeback.sv
// Register writeback queue: buffers register-file writes, drains them in order, and tracks pending writes per register.
// Optional same-cycle bypass of an empty queue is enabled by defining WB_BYPASS_EN.
module reg_writeback #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [2:0]  wb_dr,
  input  logic [15:0] wb_data,
  input  logic        wb_stall,
  output logic        regWE,
  output logic [2:0]  DR,
  output logic [15:0] Buss,
  input  logic [2:0]  SR1,
  input  logic [2:0]  SR2,
  output logic        sr1_busy,
  output logic        sr2_busy,
  output logic [2:0]  count
);

  localparam int unsigned PW    = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned DW    = 16;
  localparam int unsigned RW    = 3;
  localparam int unsigned NREGS = 8;

  logic [DW-1:0] r_data [DEPTH];
  logic [RW-1:0] r_dr   [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [2:0]    r_count;
  logic [2:0]    r_pend [NREGS];

  logic w_byp;
  logic w_pop;
  logic w_enq;

  assign wb_ready = (r_count != 3'(DEPTH));
  assign count    = r_count;

`ifdef WB_BYPASS_EN
  // An empty, unstalled queue forwards the request straight to the register file.
  assign w_byp = wb_valid && !wb_stall && (r_count == 3'd0);
`else
  assign w_byp = 1'b0;
`endif

  assign w_pop = (r_count != 3'd0) && !wb_stall;
  assign w_enq = wb_valid && wb_ready && !w_byp;

  always_comb begin
    regWE = 1'b0;
    DR    = '0;
    Buss  = '0;
    if (w_byp) begin
      regWE = 1'b1;
      DR    = wb_dr;
      Buss  = wb_data;
    end else if (w_pop) begin
      regWE = 1'b1;
      DR    = r_dr[r_head];
      Buss  = r_data[r_head];
    end
  end

  assign sr1_busy = (r_pend[SR1] != 3'd0);
  assign sr2_busy = (r_pend[SR2] != 3'd0);

  // Queue storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_enq && !reset) begin
      r_data[r_tail] <= wb_data;
      r_dr[r_tail]   <= wb_dr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= (r_head == PW'(DEPTH - 1)) ? '0 : r_head + PW'(1);
      end
      if (w_enq) begin
        r_tail <= (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + PW'(1);
      end
      if (w_enq && !w_pop) begin
        r_count <= r_count + 3'd1;
      end else if (w_pop && !w_enq) begin
        r_count <= r_count - 3'd1;
      end
    end
  end

  // Per-register pending-write counters; matching enqueue and pop cancel out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset) begin
        r_pend[i] <= '0;
      end else begin
        if ((w_enq && (wb_dr == RW'(i))) && !(w_pop && (r_dr[r_head] == RW'(i)))) begin
          r_pend[i] <= r_pend[i] + 3'd1;
        end else if (!(w_enq && (wb_dr == RW'(i))) && (w_pop && (r_dr[r_head] == RW'(i)))) begin
          r_pend[i] <= r_pend[i] - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized self-checking bench for reg_writeback against a queue-based reference model.
// Directed sequences pin the model with literal expectations; WB_BYPASS_EN selects the bypass build.
module tb_reg_writeback;

  localparam int unsigned DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, wb_valid, wb_ready, wb_stall, regWE, sr1_busy, sr2_busy;
  logic [2:0]  wb_dr, DR, SR1, SR2, count;
  logic [15:0] wb_data, Buss;

  typedef struct packed {
    logic [2:0]  dr;
    logic [15:0] data;
  } ent_t;

  ent_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dr(wb_dr), .wb_data(wb_data), .wb_stall(wb_stall), .regWE(regWE),
    .DR(DR), .Buss(Buss), .SR1(SR1), .SR2(SR2), .sr1_busy(sr1_busy),
    .sr2_busy(sr2_busy), .count(count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int pending(input logic [2:0] r);
    int n = 0;
    foreach (q[i]) if (q[i].dr == r) n++;
    return n;
  endfunction

  function automatic bit model_byp();
    return BYP && wb_valid && !wb_stall && (q.size() == 0);
  endfunction

  // Compares every DUT output with what the model says it must be this cycle.
  task automatic compare();
    logic        e_we;
    logic [2:0]  e_dr;
    logic [15:0] e_data;
    e_we = 1'b0; e_dr = '0; e_data = '0;
    if (model_byp()) begin
      e_we = 1'b1; e_dr = wb_dr; e_data = wb_data;
    end else if (q.size() != 0 && !wb_stall) begin
      e_we = 1'b1; e_dr = q[0].dr; e_data = q[0].data;
    end
    chk("wb_ready", 32'(wb_ready), 32'(q.size() != DEPTH));
    chk("count", 32'(count), 32'(q.size()));
    chk("regWE", 32'(regWE), 32'(e_we));
    chk("DR", 32'(DR), 32'(e_dr));
    chk("Buss", 32'(Buss), 32'(e_data));
    chk("sr1_busy", 32'(sr1_busy), 32'(pending(SR1) != 0));
    chk("sr2_busy", 32'(sr2_busy), 32'(pending(SR2) != 0));
  endtask

  task automatic drive(input logic v, input logic [2:0] dr, input logic [15:0] data,
                       input logic st, input logic rst);
    wb_valid = v; wb_dr = dr; wb_data = data; wb_stall = st; reset = rst;
    @(negedge clk);
    compare();
  endtask

  // Advances one edge and applies the same edge to the model.
  task automatic tick();
    bit do_pop, do_enq;
    ent_t e;
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      do_pop = (q.size() != 0) && !wb_stall;
      do_enq = wb_valid && (q.size() != DEPTH) && !model_byp();
      e.dr = wb_dr; e.data = wb_data;
      if (do_pop) void'(q.pop_front());
      if (do_enq) q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input logic st);
    drive(1'b0, 3'd0, 16'h0, st, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    tick();
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_dr = '0; wb_data = '0; wb_stall = 1'b0;
    SR1 = '0; SR2 = '0;
    @(posedge clk); #1;
    q.delete();

    // Reset state
    SR1 = 3'd3; SR2 = 3'd5;
    idle(1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(wb_ready), 32'd1);
    chk("rst_regWE", 32'(regWE), 32'd0);
    chk("rst_busy", 32'({sr1_busy, sr2_busy}), 32'd0);
    tick();

`ifdef WB_BYPASS_EN
    drive(1'b1, 3'd7, 16'hBEEF, 1'b0, 1'b0);
    chk("byp_regWE", 32'(regWE), 32'd1);
    chk("byp_DR", 32'(DR), 32'd7);
    chk("byp_Buss", 32'(Buss), 32'hBEEF);
    chk("byp_ready", 32'(wb_ready), 32'd1);
    tick();
    idle(1'b0);
    chk("byp_count", 32'(count), 32'd0);
    tick();
`else
    drive(1'b1, 3'd3, 16'h1234, 1'b0, 1'b0);
    chk("lat_regWE0", 32'(regWE), 32'd0);
    tick();
    idle(1'b0);
    chk("lat_regWE", 32'(regWE), 32'd1);
    chk("lat_DR", 32'(DR), 32'd3);
    chk("lat_Buss", 32'(Buss), 32'h1234);
    chk("lat_count1", 32'(count), 32'd1);
    chk("lat_busy", 32'(sr1_busy), 32'd1);
    tick();
    idle(1'b0);
    chk("lat_count0", 32'(count), 32'd0);
    chk("lat_busy0", 32'(sr1_busy), 32'd0);
    tick();
`endif

    // Fill under stall, fifth request ignored, then in-order drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(i), 16'hA0 + 16'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 3'd4, 16'hA4, 1'b1, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(wb_ready), 32'd0);
    tick();
    idle(1'b1);
    chk("full_ignored", 32'(count), 32'd4);
    tick();
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk("drain_DR", 32'(DR), 32'(i));
      chk("drain_Buss", 32'(Buss), 32'hA0 + 32'(i));
      tick();
    end
    idle(1'b0);
    chk("drain_empty", 32'(regWE), 32'd0);
    tick();

    // Two writes to one register, busy until the last pops
    SR2 = 3'd5;
    drive(1'b1, 3'd5, 16'd1, 1'b1, 1'b0); tick();
    drive(1'b1, 3'd5, 16'd2, 1'b1, 1'b0); tick();
    idle(1'b0);
    chk("dup_Buss1", 32'(Buss), 32'd1);
    chk("dup_busy1", 32'(sr2_busy), 32'd1);
    tick();
    idle(1'b0);
    chk("dup_Buss2", 32'(Buss), 32'd2);
    chk("dup_busy2", 32'(sr2_busy), 32'd1);
    tick();
    idle(1'b0);
    chk("dup_busy0", 32'(sr2_busy), 32'd0);
    tick();

    // Full queue, continuous requests without stall
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(i + 1), 16'hC0 + 16'(i), 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 16'hD0 + 16'(i), 1'b0, 1'b0);
      if (i == 0) chk("stream_first", 32'(Buss), 32'hC0);
      tick();
    end
    idle(1'b1);
    chk("stream_count", 32'(count), 32'd3);
    tick();

    // Reset discards queued writes
    do_reset();
    SR1 = 3'd1; SR2 = 3'd2;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(i), 16'hE0 + 16'(i), 1'b1, 1'b0);
      tick();
    end
    do_reset();
    idle(1'b0);
    chk("rst3_count", 32'(count), 32'd0);
    chk("rst3_regWE", 32'(regWE), 32'd0);
    chk("rst3_busy", 32'({sr1_busy, sr2_busy}), 32'd0);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      SR1 = 3'($urandom);
      SR2 = 3'($urandom);
      drive(1'($urandom_range(0, 2) != 0), 3'($urandom), 16'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 99) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
